// File: rtl/dmem_dump_pkg.sv
// Shared types for the dmem dump sequencer: FSM state encoding and default dump depth.
package dmem_dump_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;
  localparam int unsigned DUMP_DEPTH_DEFAULT = 64;
endpackage

// File: rtl/dmem_port_mux.sv
// Combinational dmem port select: datapath pass-through when idle, dump engine owns the port when busy.
module dmem_port_mux
  import dmem_dump_pkg::*;
#(
  parameter int unsigned N  = 64,
  parameter int unsigned AW = 6
) (
  input  logic          busy,
  input  logic          dump_rd,
  input  logic [AW-1:0] idx,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_writeData,
  input  logic          cpu_writeEnable,
  input  logic          cpu_readEnable,
  output logic [N-1:0]  cpu_readData,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_writeData,
  output logic          mem_writeEnable,
  output logic          mem_readEnable,
  input  logic [N-1:0]  mem_readData
);
  // Byte-offset and high address bits are not part of the word index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[N-1:AW+3], cpu_addr[2:0]};

  assign mem_writeData = cpu_writeData;

  always_comb begin
    mem_addr        = cpu_addr[AW+2:3];
    mem_writeEnable = cpu_writeEnable;
    mem_readEnable  = cpu_readEnable;
    cpu_readData    = mem_readData;
    if (busy) begin
      // Stalled processor replays its store after release, so dropping it here is safe.
      mem_addr        = idx;
      mem_writeEnable = 1'b0;
      mem_readEnable  = dump_rd;
      cpu_readData    = '0;
    end
  end
endmodule

// File: rtl/dmem_dump_ctrl.sv
// Dump sequencer: stalls the datapath and streams every dmem word out over valid/ready.
module dmem_dump_ctrl
  import dmem_dump_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = DUMP_DEPTH_DEFAULT,
  parameter int unsigned AW    = 6
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          dump_req,
  input  logic [N-1:0]  cpu_addr,
  input  logic [N-1:0]  cpu_writeData,
  input  logic          cpu_writeEnable,
  input  logic          cpu_readEnable,
  output logic [N-1:0]  cpu_readData,
  output logic          cpu_stall,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_writeData,
  output logic          mem_writeEnable,
  output logic          mem_readEnable,
  input  logic [N-1:0]  mem_readData,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW-1:0] out_index,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  dump_state_t   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] out_index_q, out_index_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = FETCH;
          idx_d   = '0;
        end
      end
      FETCH: begin
        out_data_d  = mem_readData;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign cpu_stall = busy;
  assign done      = (state_q == DONE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = (out_index_q == LAST_IDX);

  dmem_port_mux #(
    .N  (N),
    .AW (AW)
  ) u_port_mux (
    .busy            (busy),
    .dump_rd         (state_q == FETCH),
    .idx             (idx_q),
    .cpu_addr        (cpu_addr),
    .cpu_writeData   (cpu_writeData),
    .cpu_writeEnable (cpu_writeEnable),
    .cpu_readEnable  (cpu_readEnable),
    .cpu_readData    (cpu_readData),
    .mem_addr        (mem_addr),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .mem_readEnable  (mem_readEnable),
    .mem_readData    (mem_readData)
  );
endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Scoreboard bench for dmem_dump_ctrl: directed stimulus pushes expected dump words, a monitor pops them.
module tb_dmem_dump_ctrl;
  localparam int N     = 64;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b0;
  logic          dump_req = 1'b0;
  logic [N-1:0]  cpu_addr = '0;
  logic [N-1:0]  cpu_writeData = '0;
  logic          cpu_writeEnable = 1'b0;
  logic          cpu_readEnable = 1'b0;
  logic [N-1:0]  cpu_readData;
  logic          cpu_stall;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_writeData;
  logic          mem_writeEnable;
  logic          mem_readEnable;
  logic [N-1:0]  mem_readData;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [N-1:0]  out_data;
  logic [AW-1:0] out_index;
  logic          out_last;
  logic          busy;
  logic          done;

  dmem_dump_ctrl #(.N(N), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .dump_req(dump_req),
    .cpu_addr(cpu_addr), .cpu_writeData(cpu_writeData),
    .cpu_writeEnable(cpu_writeEnable), .cpu_readEnable(cpu_readEnable),
    .cpu_readData(cpu_readData), .cpu_stall(cpu_stall),
    .mem_addr(mem_addr), .mem_writeData(mem_writeData),
    .mem_writeEnable(mem_writeEnable), .mem_readEnable(mem_readEnable),
    .mem_readData(mem_readData), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [N-1:0] mem [DEPTH];
  assign mem_readData = mem[mem_addr];
  always @(posedge CLOCK_50) if (mem_writeEnable) mem[mem_addr] <= mem_writeData;

  typedef struct {
    logic [AW-1:0] idx;
    logic [N-1:0]  data;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   checks = 0;
  int   failures = 0;
  int   words_seen = 0;

  // Monitor: a transfer happens at the next rising edge whenever valid&&ready is seen mid-cycle.
  always @(negedge CLOCK_50) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      words_seen++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected_word act_index=%0d act_data=%0h req=none", out_index, out_data);
      end else begin
        e_mon = sb.pop_front();
        if (out_index !== e_mon.idx || out_data !== e_mon.data || out_last !== (e_mon.idx == 6'd63)) begin
          failures++;
          $display("FAIL sb_word act_index=%0d act_data=%0h act_last=%0b req_index=%0d req_data=%0h req_last=%0b",
                   out_index, out_data, out_last, e_mon.idx, e_mon.data, (e_mon.idx == 6'd63));
        end
      end
    end
  end

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h req=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Called in the first FETCH cycle; returns the cycle number (FETCH=1) at which done is seen.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic push_dump(input logic [N-1:0] word2);
    exp_t e;
    for (int i = 0; i < DEPTH; i++) begin
      e.idx  = AW'(i);
      e.data = (i == 2) ? word2 : N'(i * 3);
      sb.push_back(e);
    end
  endtask

  initial begin
    int cyc;
    int base;
    int k;

    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_out_index", 64'(out_index), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Pass-through store then load
    cpu_addr = 64'h18; cpu_writeData = 64'hDEAD; cpu_writeEnable = 1'b1;
    #1;
    chk("pt_st_mem_addr", 64'(mem_addr), 64'd3);
    chk("pt_st_we", 64'(mem_writeEnable), 64'd1);
    tick();
    cpu_writeEnable = 1'b0; cpu_readEnable = 1'b1;
    #1;
    chk("pt_ld_mem_addr", 64'(mem_addr), 64'd3);
    chk("pt_ld_data", cpu_readData, 64'hDEAD);
    chk("pt_ld_stall", 64'(cpu_stall), 64'd0);
    chk("pt_ld_out_valid", 64'(out_valid), 64'd0);
    tick();
    cpu_readEnable = 1'b0;

    // Full dump, out_ready tied high
    for (int i = 0; i < DEPTH; i++) mem[i] = N'(i * 3);
    base = words_seen;
    push_dump(64'd6);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    wait_done(cyc);
    chk("full_done_cycle", 64'(cyc), 64'd129);
    chk("full_stall_in_done", 64'(cpu_stall), 64'd1);
    tick();
    chk("full_stall_after", 64'(cpu_stall), 64'd0);
    chk("full_done_pulse", 64'(done), 64'd0);
    chk("full_words", 64'(words_seen - base), 64'd64);

    // Backpressure at index 5
    push_dump(64'd6);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    k = 0;
    while (!(mem_readEnable && mem_addr == 6'd5) && k < 100) begin tick(); k++; end
    chk("bp_reach_fetch5", 64'(mem_addr), 64'd5);
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_index", 64'(out_index), 64'd5);
      chk("bp_hold_data", out_data, 64'd15);
      chk("bp_hold_idx", 64'(mem_addr), 64'd5);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_gap_valid", 64'(out_valid), 64'd0);
    tick();
    chk("bp_w6_valid", 64'(out_valid), 64'd1);
    chk("bp_w6_index", 64'(out_index), 64'd6);
    wait_done(cyc);
    tick();

    // Store on the dump_req cycle lands; store mid-dump is blocked
    cpu_addr = 64'h10; cpu_writeData = 64'h1234; cpu_writeEnable = 1'b1;
    dump_req = 1'b1;
    push_dump(64'h1234);
    tick();
    dump_req = 1'b0;
    cpu_addr = 64'h08; cpu_writeData = 64'hBEEF;
    tick(); tick();
    chk("blk_mem_we", 64'(mem_writeEnable), 64'd0);
    chk("blk_cpu_rd", cpu_readData, 64'd0);
    wait_done(cyc);
    cpu_writeEnable = 1'b0;
    tick();
    chk("blk_mem1", mem[1], 64'd3);
    chk("blk_mem2", mem[2], 64'h1234);
    chk("blk_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-dump at index 20
    base = words_seen;
    push_dump(64'h1234);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    k = 0;
    while (!(out_valid && out_index == 6'd20) && k < 100) begin tick(); k++; end
    chk("mr_reach_20", 64'(out_index), 64'd20);
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_cpu_stall", 64'(cpu_stall), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_words", 64'(words_seen - base), 64'd20);
    sb.delete();
    tick();
    reset = 1'b1;
    tick();
    chk("mr_post_valid", 64'(out_valid), 64'd0);
    base = words_seen;
    push_dump(64'h1234);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("mr_restart_addr", 64'(mem_addr), 64'd0);
    wait_done(cyc);
    tick();
    chk("mr_restart_words", 64'(words_seen - base), 64'd64);

    // Back-to-back dumps with dump_req held
    base = words_seen;
    push_dump(64'h1234);
    push_dump(64'h1234);
    dump_req = 1'b1;
    tick();
    wait_done(cyc);
    chk("b2b_done_cycle", 64'(cyc), 64'd129);
    tick();
    chk("b2b_idle_stall", 64'(cpu_stall), 64'd0);
    chk("b2b_idle_busy", 64'(busy), 64'd0);
    tick();
    chk("b2b_restart_busy", 64'(busy), 64'd1);
    chk("b2b_restart_addr", 64'(mem_addr), 64'd0);
    chk("b2b_restart_rd", 64'(mem_readEnable), 64'd1);
    dump_req = 1'b0;
    wait_done(cyc);
    tick();
    chk("b2b_words", 64'(words_seen - base), 64'd128);
    chk("b2b_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
